// File: rtl/dispense_pkg.sv
// Shared definitions for the dispense sequencer: FSM state encoding and
// servo/motor direction constants.
package dispense_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_COLOR = 3'd1,
    DISPENSE   = 3'd2,
    CAR        = 3'd3,
    RETURN     = 3'd4,
    DONE       = 3'd5
  } state_e;

  localparam logic DIR_FWD = 1'b1;
  localparam logic DIR_REV = 1'b0;

endpackage

// File: rtl/dispense_sequencer_tick_timer.sv
// tick_timer: loadable down counter that saturates at zero.
// expired_o is high while the count is zero.
module tick_timer #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             expired_o
);

  logic [CNT_W-1:0] cnt_q;

  // Load has priority; otherwise count down and stick at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              cnt_q <= '0;
    else if (load_i)         cnt_q <= load_val_i;
    else if (cnt_q != '0)    cnt_q <= cnt_q - CNT_W'(1);
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/dispense_sequencer.sv
// dispense_sequencer: per round, wait for a confirmed colour, pulse that
// colour's motor for MOTOR_TICKS cycles, then drive the car for CAR_TICKS.
// Repeats NUM_ROUNDS times. Optional macro CAR_RETURN_EN adds a reverse
// car move of NUM_ROUNDS*CAR_TICKS cycles after the last round.
// All outputs are registered from the next state (Moore).
module dispense_sequencer
  import dispense_pkg::*;
#(
  parameter int NUM_COLORS  = 3,
  parameter int NUM_ROUNDS  = 3,
  parameter int ID_W        = 4,
  parameter int MOTOR_TICKS = 50000000,
  parameter int CAR_TICKS   = 100000000,
  parameter int CNT_W       = 32,
  localparam int RW         = $clog2(NUM_ROUNDS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ID_W-1:0]       color_id,
  input  logic                  confirm,
  output logic [NUM_COLORS-1:0] motor_en,
  output logic [NUM_COLORS-1:0] motor_dir,
  output logic                  car_en,
  output logic                  car_dir,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [RW-1:0]         round_idx
);

  localparam int SEL_W = (NUM_COLORS > 1) ? $clog2(NUM_COLORS) : 1;
  localparam logic [ID_W:0]    NCOL   = (ID_W+1)'(NUM_COLORS);
  localparam logic [RW-1:0]    LAST_R = RW'(NUM_ROUNDS - 1);
  localparam logic [CNT_W-1:0] MOT_LD = CNT_W'(MOTOR_TICKS - 1);
  localparam logic [CNT_W-1:0] CAR_LD = CNT_W'(CAR_TICKS - 1);
`ifdef CAR_RETURN_EN
  localparam logic [CNT_W-1:0] RET_LD =
    CNT_W'(64'(NUM_ROUNDS) * 64'(CAR_TICKS) - 64'd1);
`endif

  state_e                  state_q, state_d;
  logic [SEL_W-1:0]        sel_q, sel_d;
  logic [RW-1:0]           round_q, round_d;
  logic                    confirm_q;
  logic                    conf_edge;
  logic                    t_load, t_expired;
  logic [CNT_W-1:0]        t_val;
  logic [NUM_COLORS-1:0]   motor_q, motor_d;
  logic                    car_en_q, car_en_d, car_dir_q, car_dir_d;
  logic                    busy_q, busy_d, done_q, done_d, err_q, err_d;

  assign conf_edge = confirm & ~confirm_q;

  tick_timer #(.CNT_W(CNT_W)) u_timer (
    .clk        (clk),
    .rst_n      (rst),
    .load_i     (t_load),
    .load_val_i (t_val),
    .expired_o  (t_expired)
  );

  // Next-state, round/selection bookkeeping, timer loads and output decode.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    round_d = round_q;
    t_load  = 1'b0;
    t_val   = '0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: if (start) begin
        state_d = WAIT_COLOR;
        round_d = '0;
      end
      WAIT_COLOR: if (conf_edge) begin
        if ({1'b0, color_id} < NCOL) begin
          sel_d   = color_id[SEL_W-1:0];
          state_d = DISPENSE;
          t_load  = 1'b1;
          t_val   = MOT_LD;
        end else begin
          err_d = 1'b1;
        end
      end
      DISPENSE: if (t_expired) begin
        state_d = CAR;
        t_load  = 1'b1;
        t_val   = CAR_LD;
      end
      CAR: if (t_expired) begin
        if (round_q == LAST_R) begin
`ifdef CAR_RETURN_EN
          state_d = RETURN;
          t_load  = 1'b1;
          t_val   = RET_LD;
`else
          state_d = DONE;
`endif
        end else begin
          round_d = round_q + RW'(1);
          state_d = WAIT_COLOR;
        end
      end
`ifdef CAR_RETURN_EN
      RETURN: if (t_expired) state_d = DONE;
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Abort overrides every other event in any active state.
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      round_d = '0;
      t_load  = 1'b1;
      t_val   = '0;
      err_d   = 1'b0;
    end

    motor_d   = (state_d == DISPENSE) ? (NUM_COLORS'(1) << sel_d) : '0;
    car_en_d  = (state_d == CAR);
    car_dir_d = (state_d == CAR) ? DIR_FWD : DIR_REV;
`ifdef CAR_RETURN_EN
    if (state_d == RETURN) car_en_d = 1'b1;
`endif
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State, bookkeeping and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      round_q   <= '0;
      confirm_q <= 1'b0;
      motor_q   <= '0;
      car_en_q  <= 1'b0;
      car_dir_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      round_q   <= round_d;
      confirm_q <= confirm;
      motor_q   <= motor_d;
      car_en_q  <= car_en_d;
      car_dir_q <= car_dir_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign motor_en  = motor_q;
  assign motor_dir = motor_q;
  assign car_en    = car_en_q;
  assign car_dir   = car_dir_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign round_idx = round_q;

endmodule
